// File: rtl/riscv_pkg.sv
// riscv_pkg -- shared RV32I constants for the micro-op encoder and the decode
// controller: micro-op class codes, major opcodes, func3/func7 values, the
// FIFO state encoding and a signed-range helper used by the legality checks.
package riscv_pkg;

  // Micro-op class as presented on in_class.
  typedef enum logic [2:0] {
    CLS_R    = 3'd0,
    CLS_I    = 3'd1,
    CLS_LOAD = 3'd2,
    CLS_JALR = 3'd3,
    CLS_S    = 3'd4,
    CLS_B    = 3'd5,
    CLS_J    = 3'd6,
    CLS_U    = 3'd7
  } uop_class_e;

  // RV32I major opcodes.
  localparam logic [6:0] OPC_R    = 7'b0110011;
  localparam logic [6:0] OPC_I    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD = 7'b0000011;
  localparam logic [6:0] OPC_JALR = 7'b1100111;
  localparam logic [6:0] OPC_S    = 7'b0100011;
  localparam logic [6:0] OPC_B    = 7'b1100011;
  localparam logic [6:0] OPC_J    = 7'b1101111;
  localparam logic [6:0] OPC_U    = 7'b0110111;

  // func3 values referenced by the legality rules.
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_JALR = 3'b000;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;

  // func7 values for R-class.
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Occupancy states of the two-entry output buffer.
  typedef enum logic [1:0] {
    FIFO_EMPTY = 2'd0,
    FIFO_ONE   = 2'd1,
    FIFO_FULL  = 2'd2
  } fifo_state_e;

  // True when v, read as two's complement, is representable in msb+1 bits,
  // i.e. bits [31:msb] are all copies of the sign bit.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned msb);
    logic [31:0] top;
    top = $signed(v) >>> msb;
    return (top == 32'h0000_0000) || (top == 32'hFFFF_FFFF);
  endfunction

endpackage

// File: rtl/fifo2.sv
// fifo2 -- two-entry first-word-fall-through buffer.
//   clk, rst (async active-low), flush (sync clear)
//   push/din   : write side (caller guarantees !full when pushing)
//   pop        : read side, consumes dout when valid
//   dout/valid : head entry and its presence flag (registered)
//   not_full   : room for at least one more entry (registered)
// Entry 0 is always the head, so dout comes straight from a flop.
module fifo2
  import riscv_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic         not_full
);

  fifo_state_e  state_q, state_d;
  logic [W-1:0] e0_q, e0_d;
  logic [W-1:0] e1_q, e1_d;
  logic         valid_q, valid_d;
  logic         not_full_q, not_full_d;

  // Next-state and storage update for the occupancy FSM.
  always_comb begin
    state_d = state_q;
    e0_d    = e0_q;
    e1_d    = e1_q;
    if (flush) begin
      state_d = FIFO_EMPTY;
      e0_d    = {W{1'b0}};
      e1_d    = {W{1'b0}};
    end else begin
      case (state_q)
        FIFO_EMPTY: begin
          if (push) begin
            e0_d    = din;
            state_d = FIFO_ONE;
          end else begin
            state_d = FIFO_EMPTY;
          end
        end
        FIFO_ONE: begin
          if (push && pop) begin
            // Head leaves and the new word becomes the head.
            e0_d    = din;
            state_d = FIFO_ONE;
          end else if (push) begin
            e1_d    = din;
            state_d = FIFO_FULL;
          end else if (pop) begin
            state_d = FIFO_EMPTY;
          end else begin
            state_d = FIFO_ONE;
          end
        end
        FIFO_FULL: begin
          if (pop) begin
            e0_d    = e1_q;
            state_d = FIFO_ONE;
          end else begin
            state_d = FIFO_FULL;
          end
        end
        default: begin
          state_d = FIFO_EMPTY;
        end
      endcase
    end
    valid_d    = (state_d != FIFO_EMPTY);
    not_full_d = (state_d != FIFO_FULL);
  end

  // State, storage and status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= FIFO_EMPTY;
      e0_q       <= {W{1'b0}};
      e1_q       <= {W{1'b0}};
      valid_q    <= 1'b0;
      not_full_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      e0_q       <= e0_d;
      e1_q       <= e1_d;
      valid_q    <= valid_d;
      not_full_q <= not_full_d;
    end
  end

  assign dout     = e0_q;
  assign valid    = valid_q;
  assign not_full = not_full_q;

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder -- turns micro-ops into RV32I instruction words.
//   clk, rst (async active-low), flush (sync clear of buffer and address)
//   in_valid/in_ready + in_class/in_func3/in_sub/in_rd/in_rs1/in_rs2/in_imm
//   out_valid/out_ready + out_instr/out_addr
//   illegal   : sticky, set by any rejected micro-op
//   err_count : saturating count of rejected micro-ops
// Legal micro-ops are encoded combinationally and pushed with their address
// into a two-entry buffer; illegal ones are dropped without using an address.
module instr_encoder
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_class,
  input  logic [2:0]  in_func3,
  input  logic        in_sub,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        illegal,
  output logic [7:0]  err_count
);

  uop_class_e  cls_s;
  logic        legal_s;
  logic [31:0] enc_s;
  logic        accept_s, push_s, pop_s;
  logic        fifo_not_full_s;
  logic [63:0] fifo_dout_s;

  logic [31:0] addr_q, addr_d;
  logic        illegal_q, illegal_d;
  logic [7:0]  err_q, err_d;
  // Held low through reset so in_ready only rises on the first edge after release.
  logic        ready_en_q, ready_en_d;

  assign cls_s = uop_class_e'(in_class);

  // Legality of the presented micro-op (func3 subset and immediate range).
  always_comb begin
    legal_s = 1'b0;
    case (cls_s)
      CLS_R:    legal_s = (in_func3 != F3_SLL) && (!in_sub || (in_func3 == F3_ADD));
      CLS_I:    legal_s = (in_func3 != F3_SLL) && (in_func3 != F3_SR) &&
                          fits_signed(in_imm, 32'd11);
      CLS_LOAD: legal_s = (in_func3 == F3_LW) && fits_signed(in_imm, 32'd11);
      CLS_JALR: legal_s = (in_func3 == F3_JALR) && fits_signed(in_imm, 32'd11);
      CLS_S:    legal_s = (in_func3 == F3_SW) && fits_signed(in_imm, 32'd11);
      CLS_B:    legal_s = ((in_func3 == F3_BEQ) || (in_func3 == F3_BNE) ||
                           (in_func3 == F3_BLT) || (in_func3 == F3_BGE)) &&
                          fits_signed(in_imm, 32'd12) && !in_imm[0];
      CLS_J:    legal_s = fits_signed(in_imm, 32'd20) && !in_imm[0];
      CLS_U:    legal_s = (in_imm[11:0] == 12'h000);
      default:  legal_s = 1'b0;
    endcase
  end

  // Field placement for each RV32I format.
  always_comb begin
    enc_s = 32'h0000_0000;
    case (cls_s)
      CLS_R:    enc_s = {(in_sub ? F7_ALT : F7_BASE), in_rs2, in_rs1, in_func3, in_rd, OPC_R};
      CLS_I:    enc_s = {in_imm[11:0], in_rs1, in_func3, in_rd, OPC_I};
      CLS_LOAD: enc_s = {in_imm[11:0], in_rs1, in_func3, in_rd, OPC_LOAD};
      CLS_JALR: enc_s = {in_imm[11:0], in_rs1, in_func3, in_rd, OPC_JALR};
      CLS_S:    enc_s = {in_imm[11:5], in_rs2, in_rs1, in_func3, in_imm[4:0], OPC_S};
      CLS_B:    enc_s = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_func3,
                         in_imm[4:1], in_imm[11], OPC_B};
      CLS_J:    enc_s = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OPC_J};
      CLS_U:    enc_s = {in_imm[31:12], in_rd, OPC_U};
      default:  enc_s = 32'h0000_0000;
    endcase
  end

  assign in_ready = ready_en_q && fifo_not_full_s && !flush;
  assign accept_s = in_valid && in_ready;
  assign push_s   = accept_s && legal_s;
  assign pop_s    = out_valid && out_ready;

  // Address counter, error flags and ready enable next values.
  always_comb begin
    ready_en_d = 1'b1;
    if (flush) begin
      addr_d = 32'h0000_0000;
    end else if (push_s) begin
      addr_d = addr_q + 32'd4;
    end else begin
      addr_d = addr_q;
    end
    if (accept_s && !legal_s) begin
      illegal_d = 1'b1;
      err_d     = (err_q == 8'hFF) ? err_q : (err_q + 8'd1);
    end else begin
      illegal_d = illegal_q;
      err_d     = err_q;
    end
  end

  // Address counter, error flags and ready enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q     <= 32'h0000_0000;
      illegal_q  <= 1'b0;
      err_q      <= 8'h00;
      ready_en_q <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      illegal_q  <= illegal_d;
      err_q      <= err_d;
      ready_en_q <= ready_en_d;
    end
  end

  fifo2 #(.W(64)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .push     (push_s),
    .din      ({addr_q, enc_s}),
    .pop      (pop_s),
    .dout     (fifo_dout_s),
    .valid    (out_valid),
    .not_full (fifo_not_full_s)
  );

  assign out_addr  = fifo_dout_s[63:32];
  assign out_instr = fifo_dout_s[31:0];
  assign illegal   = illegal_q;
  assign err_count = err_q;

endmodule
